// File: rtl/pulse_meter.sv
`default_nettype none
// ============================================================================
// Module   : pulse_meter
// Purpose  : Measures high-pulse lengths on a sampled bit stream, flags rising
//            edges, counts completed pulses and tracks dropped results.
// Revision : 1.0
// ============================================================================
module pulse_meter #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             q_i,
    output logic             edge_o,
    output logic [LEN_W-1:0] len_o,
    output logic             len_sat_o,
    output logic             len_valid_o,
    input  logic             len_ready_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             drop_o
);

    localparam logic [1:0]       c_ARM     = 2'd0;
    localparam logic [1:0]       c_LOW     = 2'd1;
    localparam logic [1:0]       c_HIGH    = 2'd2;
    localparam logic [LEN_W-1:0] c_LEN_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] len_out_q, len_out_d;
    logic             sat_q, sat_d;
    logic             valid_q, valid_d;
    logic             edge_q, edge_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic w_rise, w_done, w_free, w_load;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= c_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = c_ARM;
        end else begin
            case (state_q)
                c_ARM:   if (!q_i) state_d = c_LOW;
                c_LOW:   if (q_i)  state_d = c_HIGH;
                c_HIGH:  if (!q_i) state_d = c_LOW;
                default: state_d = c_ARM;
            endcase
        end
    end

    always_comb begin
        w_rise    = en_i && (state_q == c_LOW) && q_i;
        w_done    = en_i && (state_q == c_HIGH) && !q_i;
        // A handshake in this cycle frees the slot for a same-cycle load.
        w_free    = !valid_q || len_ready_i;
        w_load    = w_done && w_free;
        edge_d    = w_rise;

        len_d = len_q;
        if (!en_i) begin
            len_d = '0;
        end else if (w_rise) begin
            len_d = LEN_W'(1);
        end else if ((state_q == c_HIGH) && q_i && (len_q != c_LEN_MAX)) begin
            len_d = len_q + LEN_W'(1);
        end

        len_out_d = len_out_q;
        sat_d     = sat_q;
        valid_d   = valid_q;
        if (w_load) begin
            len_out_d = len_q;
            sat_d     = (len_q == c_LEN_MAX);
            valid_d   = 1'b1;
        end else if (valid_q && len_ready_i) begin
            valid_d   = 1'b0;
        end

        cnt_d  = cnt_q;
        drop_d = drop_q;
        if (clr_i) begin
            cnt_d  = '0;
            drop_d = 1'b0;
        end else if (w_done) begin
            cnt_d  = cnt_q + CNT_W'(1);
            drop_d = drop_q | !w_free;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q     <= '0;
            len_out_q <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            edge_q    <= 1'b0;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
        end else begin
            len_q     <= len_d;
            len_out_q <= len_out_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
            edge_q    <= edge_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
        end
    end

    assign edge_o      = edge_q;
    assign len_o       = len_out_q;
    assign len_sat_o   = sat_q;
    assign len_valid_o = valid_q;
    assign cnt_o       = cnt_q;
    assign drop_o      = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_meter
// Purpose  : Directed bench for pulse_meter with a pulse-level reference model,
//            running a default-width and a narrow-width instance side by side.
// Revision : 1.0
// ============================================================================
module tb_pulse_meter;

    logic clk_i       = 1'b0;
    logic rst_i       = 1'b1;
    logic en_i        = 1'b1;
    logic clr_i       = 1'b0;
    logic q_i         = 1'b0;
    logic len_ready_i = 1'b1;

    logic        d_edge, d_sat, d_valid, d_drop;
    logic [7:0]  d_len;
    logic [15:0] d_cnt;
    logic        s_edge, s_sat, s_valid, s_drop;
    logic [3:0]  s_len;
    logic [1:0]  s_cnt;

    int n_cmp    = 0;
    int n_err    = 0;
    int edge_cnt = 0;

    always #5 clk_i = ~clk_i;

    pulse_meter u_def (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .q_i(q_i),
        .edge_o(d_edge), .len_o(d_len), .len_sat_o(d_sat), .len_valid_o(d_valid),
        .len_ready_i(len_ready_i), .cnt_o(d_cnt), .drop_o(d_drop)
    );

    pulse_meter #(.LEN_W(4), .CNT_W(2)) u_small (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .q_i(q_i),
        .edge_o(s_edge), .len_o(s_len), .len_sat_o(s_sat), .len_valid_o(s_valid),
        .len_ready_i(len_ready_i), .cnt_o(s_cnt), .drop_o(s_drop)
    );

    // Pulse-level reference: a run of high samples only counts once a low
    // sample has been seen while enabled.
    typedef struct {
        int run;
        bit elig;
        bit edg;
        int len;
        bit sat;
        bit vld;
        int cnt;
        bit drop;
    } mdl_t;

    mdl_t m_def, m_small;

    function automatic mdl_t mstep(mdl_t m, int lw, int cw,
                                   bit en, bit clr, bit q, bit rdy);
        int maxl = (1 << lw) - 1;
        bit done = 1'b0;
        int dlen = 0;
        bit room = !m.vld || rdy;
        m.edg = 1'b0;
        if (!en) begin
            m.elig = 1'b0;
            m.run  = 0;
        end else if (!m.elig) begin
            if (!q) m.elig = 1'b1;
        end else if (q) begin
            if (m.run == 0) m.edg = 1'b1;
            m.run++;
        end else begin
            if (m.run > 0) begin
                done = 1'b1;
                dlen = m.run;
            end
            m.run = 0;
        end
        if (done && room) begin
            m.len = (dlen > maxl) ? maxl : dlen;
            m.sat = (dlen >= maxl);
            m.vld = 1'b1;
        end else if (m.vld && rdy) begin
            m.vld = 1'b0;
        end
        if (clr) begin
            m.cnt  = 0;
            m.drop = 1'b0;
        end else if (done) begin
            m.cnt = (m.cnt + 1) % (1 << cw);
            if (!room) m.drop = 1'b1;
        end
        return m;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_def   = '{default: 0};
            m_small = '{default: 0};
        end else begin
            m_def   = mstep(m_def,   8, 16, en_i, clr_i, q_i, len_ready_i);
            m_small = mstep(m_small, 4, 2,  en_i, clr_i, q_i, len_ready_i);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk_i) begin
        #2;
        chk("def.edge",  int'(d_edge),  int'(m_def.edg));
        chk("def.len",   int'(d_len),   m_def.len);
        chk("def.sat",   int'(d_sat),   int'(m_def.sat));
        chk("def.valid", int'(d_valid), int'(m_def.vld));
        chk("def.cnt",   int'(d_cnt),   m_def.cnt);
        chk("def.drop",  int'(d_drop),  int'(m_def.drop));
        chk("sml.edge",  int'(s_edge),  int'(m_small.edg));
        chk("sml.len",   int'(s_len),   m_small.len);
        chk("sml.sat",   int'(s_sat),   int'(m_small.sat));
        chk("sml.valid", int'(s_valid), int'(m_small.vld));
        chk("sml.cnt",   int'(s_cnt),   m_small.cnt);
        chk("sml.drop",  int'(s_drop),  int'(m_small.drop));
    end

    // Drive one sample at posedge+2, then return at the next posedge+2.
    task automatic cyc(input bit q);
        q_i = q;
        @(posedge clk_i);
        #2;
        edge_cnt += int'(d_edge);
    endtask

    task automatic cycn(input bit q, input int n);
        for (int i = 0; i < n; i++) cyc(q);
    endtask

    initial begin
        @(posedge clk_i);
        #2;
        cyc(1'b0);
        chk("rst.cnt", int'(d_cnt), 0);
        chk("rst.valid", int'(d_valid), 0);
        rst_i = 1'b0;

        // Basic 3-cycle pulse.
        cycn(1'b0, 2);
        cyc(1'b1);
        chk("p3.edge_hi", int'(d_edge), 1);
        cyc(1'b1);
        chk("p3.edge_lo", int'(d_edge), 0);
        cyc(1'b1);
        cyc(1'b0);
        chk("p3.len", int'(d_len), 3);
        chk("p3.valid", int'(d_valid), 1);
        chk("p3.cnt", int'(d_cnt), 1);
        cyc(1'b0);
        chk("p3.valid_gone", int'(d_valid), 0);
        chk("p3.drop", int'(d_drop), 0);

        // High through reset release sits in ARM.
        q_i   = 1'b1;
        rst_i = 1'b1;
        cycn(1'b1, 2);
        rst_i    = 1'b0;
        edge_cnt = 0;
        cycn(1'b1, 4);
        cyc(1'b0);
        cycn(1'b1, 2);
        cyc(1'b0);
        chk("arm.edges", edge_cnt, 1);
        chk("arm.len", int'(d_len), 2);
        chk("arm.cnt", int'(d_cnt), 1);

        // Full output register drops the second result.
        clr_i = 1'b1;
        cyc(1'b0);
        clr_i       = 1'b0;
        len_ready_i = 1'b0;
        cycn(1'b1, 5);
        cyc(1'b0);
        cycn(1'b1, 7);
        cyc(1'b0);
        chk("bp.len", int'(d_len), 5);
        chk("bp.valid", int'(d_valid), 1);
        chk("bp.drop", int'(d_drop), 1);
        chk("bp.cnt", int'(d_cnt), 2);
        len_ready_i = 1'b1;
        cyc(1'b0);
        chk("bp.valid_gone", int'(d_valid), 0);

        // Saturation on the narrow instance.
        clr_i = 1'b1;
        cyc(1'b0);
        clr_i = 1'b0;
        cycn(1'b1, 20);
        cyc(1'b0);
        chk("sat.len", int'(s_len), 15);
        chk("sat.flag", int'(s_sat), 1);
        chk("sat.def_len", int'(d_len), 20);
        cyc(1'b1);
        cyc(1'b0);
        chk("sat.len1", int'(s_len), 1);
        chk("sat.flag1", int'(s_sat), 0);

        // Back-to-back single-cycle pulses, counter wrap.
        clr_i = 1'b1;
        cyc(1'b0);
        clr_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            cyc(1'b0);
            chk("wrap.cnt", int'(s_cnt), (i + 1) % 4);
            chk("wrap.len", int'(s_len), 1);
        end
        chk("wrap.drop", int'(s_drop), 0);
        chk("wrap.def_cnt", int'(d_cnt), 5);

        // Enable dropped mid-pulse.
        cycn(1'b1, 2);
        en_i = 1'b0;
        cycn(1'b1, 4);
        cyc(1'b0);
        en_i = 1'b1;
        cyc(1'b0);
        chk("en.cnt", int'(d_cnt), 5);
        chk("en.valid", int'(d_valid), 0);

        // Enable rising while high: no edge until a low sample.
        en_i = 1'b0;
        cyc(1'b1);
        en_i     = 1'b1;
        edge_cnt = 0;
        cycn(1'b1, 2);
        chk("enr.no_edge", edge_cnt, 0);
        cyc(1'b0);
        cyc(1'b1);
        chk("enr.edge", int'(d_edge), 1);
        cyc(1'b1);

        // Asynchronous reset mid-pulse.
        #3;
        rst_i = 1'b1;
        #1;
        chk("arst.cnt", int'(d_cnt), 0);
        chk("arst.len", int'(d_len), 0);
        chk("arst.valid", int'(d_valid), 0);
        chk("arst.scnt", int'(s_cnt), 0);
        @(posedge clk_i);
        #2;
        cyc(1'b1);
        rst_i    = 1'b0;
        edge_cnt = 0;
        cycn(1'b1, 2);
        chk("arst.no_edge", edge_cnt, 0);
        chk("arst.cnt2", int'(d_cnt), 0);

        // Clear coincident with a completion.
        cyc(1'b0);
        cycn(1'b1, 2);
        clr_i = 1'b1;
        cyc(1'b0);
        clr_i = 1'b0;
        chk("clr.cnt", int'(d_cnt), 0);
        chk("clr.valid", int'(d_valid), 1);
        chk("clr.len", int'(d_len), 2);
        cycn(1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
